dtube_test_sequencer: RTL

// - Automatic test controller for the 4-digit seven-segment display driver under test.
// - Each vector: drives a 16-bit display value to the driver and triggers the capture

---
 rtl/dtube_pkg.sv | 41 ++++
 rtl/dtube_seg_expect.sv | 15 +
 rtl/dtube_test_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dtube_pkg.sv
// Shared types and the segment decode table for the display test sequencer.
// The decode table matches the one used by the display driver under test:
// common-anode, active-low, bit order {dp,g,f,e,d,c,b,a}, decimal point off.
package dtube_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        CHECK  = 3'd4,
        CLEAR  = 3'd5,
        FINISH = 3'd6
    } state_t;

    // Hex digit to 8-bit active-low segment pattern
    function automatic logic [7:0] SEG(input logic [3:0] hex);
        logic [7:0] seg_s;
        case (hex)
            4'h0:    seg_s = 8'hC0;
            4'h1:    seg_s = 8'hF9;
            4'h2:    seg_s = 8'hA4;
            4'h3:    seg_s = 8'hB0;
            4'h4:    seg_s = 8'h99;
            4'h5:    seg_s = 8'h92;
            4'h6:    seg_s = 8'h82;
            4'h7:    seg_s = 8'hF8;
            4'h8:    seg_s = 8'h80;
            4'h9:    seg_s = 8'h90;
            4'hA:    seg_s = 8'h88;
            4'hB:    seg_s = 8'h83;
            4'hC:    seg_s = 8'hC6;
            4'hD:    seg_s = 8'hA1;
            4'hE:    seg_s = 8'h86;
            4'hF:    seg_s = 8'h8E;
            default: seg_s = 8'hFF;
        endcase
        return seg_s;
    endfunction

endpackage

// File: rtl/dtube_seg_expect.sv
// Combinational expected-segment generator: four hex digits of a 16-bit
// display value decoded into the 32-bit word the capture block reports.
module dtube_seg_expect
    import dtube_pkg::*;
(
    input  logic [15:0] value,
    output logic [31:0] seg_word
);

    // Decode each nibble; digit 3 lands in the top byte
    always_comb begin
        seg_word = {SEG(value[15:12]), SEG(value[11:8]), SEG(value[7:4]), SEG(value[3:0])};
    end

endmodule

// File: rtl/dtube_test_sequencer.sv
// Automatic test controller for the 4-digit seven-segment driver.
// Per vector: drive a display value, let it settle, trigger the capture block,
// wait for its done (or time out), compare captured segments and data against
// the expected decode, then clear the capture block before the next vector.
module dtube_test_sequencer
    import dtube_pkg::*;
#(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned CLEAR_CYC   = 2
) (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    input  logic        I_run,
    input  logic        I_abort,
    input  logic [15:0] I_vec_base,
    input  logic [15:0] I_vec_step,
    input  logic [7:0]  I_vec_cnt,
    input  logic [31:0] I_mea_data0,
    input  logic [31:0] I_mea_data1,
    input  logic        I_mea_done,
    output logic [15:0] O_disp_data,
    output logic        O_test_en,
    output logic        O_mea_start,
    output logic        O_busy,
    output logic        O_done,
    output logic [7:0]  O_pass_cnt,
    output logic [7:0]  O_fail_cnt,
    output logic [7:0]  O_first_fail_idx,
    output logic        O_first_fail_vld,
    output logic        O_timeout
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned CLR_W = $clog2(CLEAR_CYC + 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLEAR_CYC - 1);

    state_t             state_r;
    logic               run_d_r;
    logic [15:0]        step_r;
    logic [7:0]         cnt_r;
    logic [7:0]         idx_r;
    logic [15:0]        cur_val_r;
    logic [SET_W-1:0]   settle_cnt_r;
    logic [TMO_W-1:0]   tmo_cnt_r;
    logic [CLR_W-1:0]   clr_cnt_r;
    logic               tmo_flag_r;

    logic [15:0]        disp_r;
    logic               test_en_r;
    logic               mea_start_r;
    logic               busy_r;
    logic               done_r;
    logic [7:0]         pass_cnt_r;
    logic [7:0]         fail_cnt_r;
    logic [7:0]         first_fail_idx_r;
    logic               first_fail_vld_r;
    logic               timeout_r;

    logic               run_edge_s;
    logic [31:0]        exp_seg_s;
    logic               vec_pass_s;
    logic               more_vec_s;
    logic               unused_data1_s;

    dtube_seg_expect u_seg_expect (
        .value    (disp_r),
        .seg_word (exp_seg_s)
    );

    // Run edge detect, per-vector verdict and "more vectors left" decision
    always_comb begin
        run_edge_s     = I_run & ~run_d_r;
        vec_pass_s     = ~tmo_flag_r && (I_mea_data1[15:0] == disp_r) && (I_mea_data0 == exp_seg_s);
        more_vec_s     = (({1'b0, idx_r} + 9'd1) < {1'b0, cnt_r});
        unused_data1_s = ^I_mea_data1[31:16];
    end

    // Sequencer FSM with all counters and registered outputs
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state_r          <= IDLE;
            run_d_r          <= 1'b0;
            step_r           <= 16'd0;
            cnt_r            <= 8'd0;
            idx_r            <= 8'd0;
            cur_val_r        <= 16'd0;
            settle_cnt_r     <= '0;
            tmo_cnt_r        <= '0;
            clr_cnt_r        <= '0;
            tmo_flag_r       <= 1'b0;
            disp_r           <= 16'd0;
            test_en_r        <= 1'b0;
            mea_start_r      <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            pass_cnt_r       <= 8'd0;
            fail_cnt_r       <= 8'd0;
            first_fail_idx_r <= 8'd0;
            first_fail_vld_r <= 1'b0;
            timeout_r        <= 1'b0;
        end else begin
            run_d_r <= I_run;
            done_r  <= 1'b0;
            if (I_abort) begin
                // Abort wins over every transition; results are kept for readback
                state_r     <= IDLE;
                test_en_r   <= 1'b0;
                mea_start_r <= 1'b0;
                busy_r      <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (run_edge_s) begin
                            step_r           <= I_vec_step;
                            cnt_r            <= I_vec_cnt;
                            cur_val_r        <= I_vec_base;
                            idx_r            <= 8'd0;
                            settle_cnt_r     <= '0;
                            pass_cnt_r       <= 8'd0;
                            fail_cnt_r       <= 8'd0;
                            first_fail_idx_r <= 8'd0;
                            first_fail_vld_r <= 1'b0;
                            timeout_r        <= 1'b0;
                            busy_r           <= 1'b1;
                            state_r          <= (I_vec_cnt != 8'd0) ? SETUP : FINISH;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    SETUP: begin
                        disp_r    <= cur_val_r;
                        test_en_r <= 1'b1;
                        if (settle_cnt_r == SET_LAST) begin
                            settle_cnt_r <= '0;
                            state_r      <= START;
                        end else begin
                            settle_cnt_r <= settle_cnt_r + 1'b1;
                        end
                    end
                    START: begin
                        mea_start_r <= 1'b1;
                        tmo_cnt_r   <= '0;
                        state_r     <= WAIT;
                    end
                    WAIT: begin
                        // A done in the same cycle as the last timeout count wins
                        if (I_mea_done) begin
                            tmo_flag_r <= 1'b0;
                            state_r    <= CHECK;
                        end else if (tmo_cnt_r == TMO_LAST) begin
                            tmo_flag_r <= 1'b1;
                            state_r    <= CHECK;
                        end else begin
                            tmo_cnt_r <= tmo_cnt_r + 1'b1;
                        end
                    end
                    CHECK: begin
                        if (vec_pass_s) begin
                            if (pass_cnt_r != 8'hFF) begin
                                pass_cnt_r <= pass_cnt_r + 8'd1;
                            end
                        end else begin
                            if (fail_cnt_r != 8'hFF) begin
                                fail_cnt_r <= fail_cnt_r + 8'd1;
                            end
                            if (!first_fail_vld_r) begin
                                first_fail_idx_r <= idx_r;
                                first_fail_vld_r <= 1'b1;
                            end
                        end
                        if (tmo_flag_r) begin
                            timeout_r <= 1'b1;
                        end
                        mea_start_r <= 1'b0;
                        test_en_r   <= 1'b0;
                        clr_cnt_r   <= '0;
                        state_r     <= CLEAR;
                    end
                    CLEAR: begin
                        // Hold the capture block cleared, then wait for its done to drop
                        if (clr_cnt_r < CLR_LAST) begin
                            clr_cnt_r <= clr_cnt_r + 1'b1;
                        end else if (!I_mea_done) begin
                            if (more_vec_s) begin
                                idx_r        <= idx_r + 8'd1;
                                cur_val_r    <= cur_val_r + step_r;
                                settle_cnt_r <= '0;
                                state_r      <= SETUP;
                            end else begin
                                state_r <= FINISH;
                            end
                        end else begin
                            state_r <= CLEAR;
                        end
                    end
                    FINISH: begin
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r     <= IDLE;
                        test_en_r   <= 1'b0;
                        mea_start_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign O_disp_data      = disp_r;
    assign O_test_en        = test_en_r;
    assign O_mea_start      = mea_start_r;
    assign O_busy           = busy_r;
    assign O_done           = done_r;
    assign O_pass_cnt       = pass_cnt_r;
    assign O_fail_cnt       = fail_cnt_r;
    assign O_first_fail_idx = first_fail_idx_r;
    assign O_first_fail_vld = first_fail_vld_r;
    assign O_timeout        = timeout_r;

endmodule
